hacd_cmd_axil_master: RTL and testbench



---
 rtl/hacd_cmd_pkg.sv | 25 ++
 rtl/hacd_sat_cnt.sv | 28 ++
 rtl/hacd_cmd_axil_master.sv | 159 +++++++++++++++
 tb/tb_hacd_cmd_axil_master.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hacd_cmd_pkg.sv
// Shared types and constants for the HACD command-register AXI-lite master.
//   hacd_state_e : transaction sequencer states
//   SZ32/SZ64    : AxSIZE encodings for 4- and 8-byte beats
//   STRB_LO/ALL  : write strobes for a low 32-bit half / full 64-bit word
//   RESP_OKAY    : AXI OKAY response code
package hacd_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_LO,
    WB_LO,
    WR_HI,
    WB_HI,
    RD,
    WR_R,
    RESP
  } hacd_state_e;

  localparam logic [2:0] SZ32      = 3'b010;
  localparam logic [2:0] SZ64      = 3'b011;
  localparam logic [7:0] STRB_LO   = 8'h0F;
  localparam logic [7:0] STRB_ALL  = 8'hFF;
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/hacd_sat_cnt.sv
// Saturating up-counter with synchronous clear and count enable.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : clear to zero (wins over en_i)
//   en_i          : increment by one, holding at all-ones
//   cnt_o         : current count
module hacd_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] One = Width'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + One;
    end
  end

endmodule

// File: rtl/hacd_cmd_axil_master.sv
// AXI-lite initiator that writes a 64-bit HAWK command into the HACD command
// register, either as one 64-bit write or as low/high 32-bit halves, with an
// optional 64-bit readback. The write phase (AW/W through B) is timed.
//   req_*    : command request (cmd, split, readback)
//   rsp_*    : response with readback data, error flag and write latency
//   m_axi_*  : AXI-lite master channels AW, W, B, AR, R
module hacd_cmd_axil_master
  import hacd_cmd_pkg::*;
#(
  parameter logic [63:0] HacdBase = 64'h000000fff5100000,
  parameter int unsigned LatW     = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [63:0]     req_cmd_i,
  input  logic            req_split_i,
  input  logic            req_readback_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [63:0]     rsp_data_o,
  output logic            rsp_err_o,
  output logic [LatW-1:0] rsp_lat_o,
  output logic [63:0]     m_axi_awaddr,
  output logic [2:0]      m_axi_awsize,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,
  output logic [63:0]     m_axi_wdata,
  output logic [7:0]      m_axi_wstrb,
  output logic            m_axi_wvalid,
  input  logic            m_axi_wready,
  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,
  output logic [63:0]     m_axi_araddr,
  output logic [2:0]      m_axi_arsize,
  output logic            m_axi_arvalid,
  input  logic            m_axi_arready,
  input  logic [63:0]     m_axi_rdata,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rvalid,
  output logic            m_axi_rready
);

  hacd_state_e state_q, state_d;
  logic [63:0] cmd_q, rdata_q;
  logic        split_q, rb_q, err_q, aw_done_q, w_done_q;
  logic        wr_phase, hi_phase, aw_all, w_all, b_err, accept, rsp_done;

  assign wr_phase = (state_q == WR_LO) || (state_q == WR_HI);
  assign hi_phase = (state_q == WR_HI);
  assign aw_all   = aw_done_q || (m_axi_awvalid && m_axi_awready);
  assign w_all    = w_done_q  || (m_axi_wvalid  && m_axi_wready);
  assign b_err    = (m_axi_bresp != RESP_OKAY);
  assign accept   = (state_q == IDLE) && req_valid_i;
  assign rsp_done = (state_q == RESP) && rsp_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready_o   = (state_q == IDLE);
    rsp_valid_o   = (state_q == RESP);
    rsp_err_o     = err_q;
    rsp_data_o    = ((state_q == RESP) && !err_q) ? rdata_q : '0;
    // Valids come from state and done flags only, never from the readies.
    m_axi_awvalid = wr_phase && !aw_done_q;
    m_axi_wvalid  = wr_phase && !w_done_q;
    m_axi_awaddr  = '0;
    m_axi_awsize  = '0;
    m_axi_wdata   = '0;
    m_axi_wstrb   = '0;
    m_axi_bready  = (state_q == WB_LO) || (state_q == WB_HI);
    m_axi_arvalid = (state_q == RD);
    m_axi_araddr  = (state_q == RD) ? HacdBase : '0;
    m_axi_arsize  = (state_q == RD) ? SZ64 : '0;
    m_axi_rready  = (state_q == WR_R);
    if (wr_phase) begin
      m_axi_awaddr = hi_phase ? (HacdBase + 64'd4) : HacdBase;
      m_axi_awsize = (hi_phase || split_q) ? SZ32 : SZ64;
      m_axi_wstrb  = (hi_phase || split_q) ? STRB_LO : STRB_ALL;
      if (hi_phase)     m_axi_wdata = {32'h0, cmd_q[63:32]};
      else if (split_q) m_axi_wdata = {32'h0, cmd_q[31:0]};
      else              m_axi_wdata = cmd_q;
    end

    unique case (state_q)
      IDLE:  if (req_valid_i) state_d = WR_LO;
      WR_LO: if (aw_all && w_all) state_d = WB_LO;
      WR_HI: if (aw_all && w_all) state_d = WB_HI;
      WB_LO, WB_HI: begin
        if (m_axi_bvalid) begin
          if ((state_q == WB_LO) && split_q && !b_err) state_d = WR_HI;
          else if (rb_q && !b_err && !err_q)            state_d = RD;
          else                                          state_d = RESP;
        end
      end
      RD:    if (m_axi_arready) state_d = WR_R;
      WR_R:  if (m_axi_rvalid)  state_d = RESP;
      RESP:  if (rsp_ready_i)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cmd_q     <= '0;
      rdata_q   <= '0;
      split_q   <= 1'b0;
      rb_q      <= 1'b0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        cmd_q   <= req_cmd_i;
        split_q <= req_split_i;
        rb_q    <= req_readback_i;
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
      // Done flags persist only until both handshakes of a beat complete.
      if (wr_phase) begin
        if (aw_all && w_all) begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end else begin
          aw_done_q <= aw_all;
          w_done_q  <= w_all;
        end
      end
      if (m_axi_bready && m_axi_bvalid && b_err) err_q <= 1'b1;
      if (m_axi_rready && m_axi_rvalid) begin
        rdata_q <= m_axi_rdata;
        if (m_axi_rresp != RESP_OKAY) err_q <= 1'b1;
      end
      if (rsp_done) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  hacd_sat_cnt #(
    .Width(LatW)
  ) u_lat_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (accept || rsp_done),
    .en_i   ((state_q == WR_LO) || (state_q == WB_LO) ||
             (state_q == WR_HI) || (state_q == WB_HI)),
    .cnt_o  (rsp_lat_o)
  );

endmodule

// File: tb/tb_hacd_cmd_axil_master.sv
// Self-checking bench for hacd_cmd_axil_master: a delay-programmable AXI-lite
// slave, directed vectors with hand-computed results, random vectors checked
// against a transaction-level model, and a mid-transaction reset sequence.
module tb_hacd_cmd_axil_master;

  localparam logic [63:0] BASE = 64'h000000fff5100000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [63:0] req_cmd_i = '0;
  logic        req_split_i = 1'b0, req_readback_i = 1'b0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [63:0] rsp_data_o;
  logic        rsp_err_o;
  logic [15:0] rsp_lat_o;
  logic [63:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [2:0]  m_axi_awsize, m_axi_arsize;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk_i = ~clk_i;

  hacd_cmd_axil_master #(
    .HacdBase(BASE),
    .LatW(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_cmd_i(req_cmd_i), .req_split_i(req_split_i),
    .req_readback_i(req_readback_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .rsp_lat_o(rsp_lat_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awsize(m_axi_awsize),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arsize(m_axi_arsize),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // ---------------- slave model: readies/valids after programmed waits
  int unsigned aw_dly = 0, w_dly = 0, b_dly0 = 0, b_dly1 = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp0 = '0, bresp1 = '0, rresp_v = '0;
  logic [63:0] rdata_v = '0;
  int unsigned aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, wr_idx, n_ar, proto_err;
  logic        aw_pend, w_pend, ar_pend;
  logic [63:0] aw_prev, w_prev, ar_prev;
  logic [63:0] aw_addr_log[$];
  logic [2:0]  aw_size_log[$];
  logic [63:0] w_data_log[$];
  logic [7:0]  w_strb_log[$];

  always_comb begin
    m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_dly);
    m_axi_wready  = m_axi_wvalid && (w_cnt >= w_dly);
    m_axi_bvalid  = m_axi_bready && (b_cnt >= ((wr_idx == 0) ? b_dly0 : b_dly1));
    m_axi_bresp   = m_axi_bvalid ? ((wr_idx == 0) ? bresp0 : bresp1) : 2'b00;
    m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_dly);
    m_axi_rvalid  = m_axi_rready && (r_cnt >= r_dly);
    m_axi_rdata   = m_axi_rvalid ? rdata_v : '0;
    m_axi_rresp   = m_axi_rvalid ? rresp_v : 2'b00;
  end

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0; wr_idx <= 0;
      aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      b_cnt  <= (m_axi_bready && !m_axi_bvalid) ? b_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (m_axi_rready && !m_axi_rvalid) ? r_cnt + 1 : 0;
      if (req_valid_i && req_ready_o) wr_idx <= 0;
      else if (m_axi_bvalid && m_axi_bready) wr_idx <= wr_idx + 1;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_addr_log.push_back(m_axi_awaddr);
        aw_size_log.push_back(m_axi_awsize);
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_data_log.push_back(m_axi_wdata);
        w_strb_log.push_back(m_axi_wstrb);
      end
      if (m_axi_arvalid && m_axi_arready) n_ar <= n_ar + 1;
      // A pending valid must stay up with unchanged payload.
      if ((aw_pend && (!m_axi_awvalid || m_axi_awaddr != aw_prev)) ||
          (w_pend && (!m_axi_wvalid || m_axi_wdata != w_prev)) ||
          (ar_pend && (!m_axi_arvalid || m_axi_araddr != ar_prev)))
        proto_err <= proto_err + 1;
      aw_pend <= m_axi_awvalid && !m_axi_awready; aw_prev <= m_axi_awaddr;
      w_pend  <= m_axi_wvalid && !m_axi_wready;   w_prev  <= m_axi_wdata;
      ar_pend <= m_axi_arvalid && !m_axi_arready; ar_prev <= m_axi_araddr;
    end
  end

  initial begin
    n_ar = 0;
    proto_err = 0;
  end

  // ---------------- vectors and reference model
  typedef struct {
    string       name;
    logic [63:0] cmd;
    logic        split, rb;
    int unsigned aw_dly, w_dly, b_dly0, b_dly1, ar_dly, r_dly;
    logic [1:0]  bresp0, bresp1, rresp;
    logic [63:0] rdata;
    int unsigned hold;
    logic        exp_err;
    logic [63:0] exp_data;
    logic [15:0] exp_lat;
    int unsigned exp_naw, exp_nar;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic int unsigned n_writes(vec_t v);
    return (v.split && v.bresp0 == 2'b00) ? 2 : 1;
  endfunction

  function automatic logic write_failed(vec_t v);
    return (v.bresp0 != 2'b00) || (n_writes(v) == 2 && v.bresp1 != 2'b00);
  endfunction

  // Cycles spent in the write phase: each beat waits for the slower of AW/W,
  // then waits for B.
  function automatic int unsigned raw_wlat(vec_t v);
    int unsigned beat;
    beat = ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + 1;
    return beat + v.b_dly0 + 1 + ((n_writes(v) == 2) ? beat + v.b_dly1 + 1 : 0);
  endfunction

  function automatic vec_t model(vec_t v);
    vec_t r = v;
    logic rd;
    int unsigned raw;
    rd = v.rb && !write_failed(v);
    raw = raw_wlat(v);
    r.exp_err  = write_failed(v) || (rd && v.rresp != 2'b00);
    r.exp_data = (rd && v.rresp == 2'b00) ? v.rdata : 64'h0;
    r.exp_lat  = (raw > 65535) ? 16'hFFFF : 16'(raw);
    r.exp_naw  = n_writes(v);
    r.exp_nar  = rd ? 1 : 0;
    return r;
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic run_txn(input vec_t v);
    int unsigned cyc, k, aw0, w0, ar0, exp_cyc;
    logic rd;
    aw_dly = v.aw_dly; w_dly = v.w_dly; b_dly0 = v.b_dly0; b_dly1 = v.b_dly1;
    ar_dly = v.ar_dly; r_dly = v.r_dly; bresp0 = v.bresp0; bresp1 = v.bresp1;
    rresp_v = v.rresp; rdata_v = v.rdata;
    aw0 = aw_addr_log.size(); w0 = w_data_log.size(); ar0 = n_ar;
    @(negedge clk_i);
    req_cmd_i = v.cmd; req_split_i = v.split; req_readback_i = v.rb;
    req_valid_i = 1'b1;
    k = 0;
    while (!req_ready_o && k < 50) begin @(negedge clk_i); k++; end
    chk({v.name, ".req_ready"}, 64'(req_ready_o), 64'h1);
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    cyc = 1;
    chk({v.name, ".aw_w_valid_t1"}, {62'h0, m_axi_awvalid, m_axi_wvalid}, 64'h3);
    while (!rsp_valid_o && cyc < 200000) begin @(posedge clk_i); #1; cyc++; end
    if (!rsp_valid_o) begin
      chk({v.name, ".rsp_timeout"}, 64'(rsp_valid_o), 64'h1);
      do_reset();
      return;
    end
    rd = v.rb && !write_failed(v);
    exp_cyc = 1 + raw_wlat(v) + (rd ? v.ar_dly + 1 + v.r_dly + 1 : 0);
    chk({v.name, ".rsp_cycle"}, 64'(cyc), 64'(exp_cyc));
    chk({v.name, ".rsp_err"}, 64'(rsp_err_o), 64'(v.exp_err));
    chk({v.name, ".rsp_data"}, rsp_data_o, v.exp_data);
    chk({v.name, ".rsp_lat"}, 64'(rsp_lat_o), 64'(v.exp_lat));
    if (v.hold > 0) begin
      repeat (v.hold) begin @(posedge clk_i); #1; end
      chk({v.name, ".rsp_held"}, {rsp_data_o[62:0], rsp_valid_o},
          {v.exp_data[62:0], 1'b1});
      chk({v.name, ".lat_held"}, 64'(rsp_lat_o), 64'(v.exp_lat));
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk({v.name, ".idle_after"}, {62'h0, rsp_valid_o, req_ready_o}, 64'h1);
    chk({v.name, ".n_aw"}, 64'(aw_addr_log.size() - aw0), 64'(v.exp_naw));
    chk({v.name, ".n_w"}, 64'(w_data_log.size() - w0), 64'(v.exp_naw));
    chk({v.name, ".n_ar"}, 64'(n_ar - ar0), 64'(v.exp_nar));
    for (int unsigned i = 0; i < v.exp_naw; i++) begin
      if (aw0 + i < aw_addr_log.size() && w0 + i < w_data_log.size()) begin
        chk({v.name, ".awaddr"}, aw_addr_log[aw0+i], BASE + 64'(4 * i));
        chk({v.name, ".awsize"}, 64'(aw_size_log[aw0+i]), v.split ? 64'h2 : 64'h3);
        chk({v.name, ".wstrb"}, 64'(w_strb_log[w0+i]), v.split ? 64'h0F : 64'hFF);
        chk({v.name, ".wdata"}, w_data_log[w0+i],
            !v.split ? v.cmd : (i == 0 ? {32'h0, v.cmd[31:0]} : {32'h0, v.cmd[63:32]}));
      end
    end
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Directed vectors: results worked out by hand.
    //            name       cmd                     sp rb aw w  b0     b1 ar r  br0    br1    rr     rdata                   hold err data                     lat       naw nar
    tbl[0] = '{"plain",   64'h0123_4567_89AB_CDEF, 0, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 2'b00, 64'h0,                  0, 0, 64'h0,                  16'd2,    1, 0};
    tbl[1] = '{"split",   64'h0123_4567_89AB_CDEF, 1, 0, 0, 0, 0,     0, 0, 0, 2'b00, 2'b00, 2'b00, 64'h0,                  0, 0, 64'h0,                  16'd4,    2, 0};
    tbl[2] = '{"rb_stall",64'h0123_4567_89AB_CDEF, 0, 1, 0, 0, 19,    0, 0, 0, 2'b00, 2'b00, 2'b00, 64'h0123_4567_89AB_CDEF, 0, 0, 64'h0123_4567_89AB_CDEF, 16'd21,   1, 1};
    tbl[3] = '{"lo_err",  64'h0123_4567_89AB_CDEF, 1, 1, 0, 0, 0,     0, 0, 0, 2'b10, 2'b00, 2'b00, 64'h5555_5555_5555_5555, 0, 1, 64'h0,                  16'd2,    1, 0};
    tbl[4] = '{"aw_late", 64'hDEAD_BEEF_0000_1111, 0, 0, 3, 0, 0,     0, 0, 0, 2'b00, 2'b00, 2'b00, 64'h0,                  5, 0, 64'h0,                  16'd5,    1, 0};
    tbl[5] = '{"rd_err",  64'hCAFE_F00D_1234_5678, 0, 1, 0, 0, 0,     0, 1, 2, 2'b00, 2'b00, 2'b10, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1, 64'h0,                  16'd2,    1, 1};
    tbl[6] = '{"sat",     64'h0000_0000_0000_0042, 0, 0, 0, 0, 66000, 0, 0, 0, 2'b00, 2'b00, 2'b00, 64'h0,                  2, 0, 64'h0,                  16'hFFFF, 1, 0};

    // Reset values.
    #2;
    chk("rst.req_ready", 64'(req_ready_o), 64'h1);
    chk("rst.valids", {59'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                       m_axi_bready, m_axi_rready}, 64'h0);
    chk("rst.rsp", {rsp_data_o[46:0], rsp_lat_o, rsp_err_o}, 64'h0);
    chk("rst.addr", m_axi_awaddr | m_axi_araddr | m_axi_wdata, 64'h0);
    chk("rst.rsp_valid", 64'(rsp_valid_o), 64'h0);
    do_reset();

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    // Random vectors against the model.
    for (int n = 0; n < 40; n++) begin
      rv.name   = $sformatf("rnd%0d", n);
      rv.cmd    = {$urandom, $urandom};
      rv.split  = 1'($urandom_range(0, 1));
      rv.rb     = 1'($urandom_range(0, 1));
      rv.aw_dly = $urandom_range(0, 4);
      rv.w_dly  = $urandom_range(0, 4);
      rv.b_dly0 = $urandom_range(0, 6);
      rv.b_dly1 = $urandom_range(0, 6);
      rv.ar_dly = $urandom_range(0, 3);
      rv.r_dly  = $urandom_range(0, 3);
      rv.bresp0 = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.bresp1 = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.rresp  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv.rdata  = {$urandom, $urandom};
      rv.hold   = $urandom_range(0, 3);
      run_txn(model(rv));
    end

    // Reset while waiting for the high-half write response.
    aw_dly = 0; w_dly = 0; b_dly0 = 0; b_dly1 = 30; bresp0 = 0; bresp1 = 0;
    @(negedge clk_i);
    req_cmd_i = 64'h1111_2222_3333_4444; req_split_i = 1'b1; req_readback_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    begin
      int unsigned k = 0;
      while (!(m_axi_bready && wr_idx == 1) && k < 100) begin @(negedge clk_i); k++; end
      chk("rstmid.reached_wb_hi", {63'h0, m_axi_bready}, 64'h1);
    end
    rst_ni = 1'b0;
    #1;
    chk("rstmid.valids", {58'h0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                          m_axi_bready, m_axi_rready, rsp_valid_o}, 64'h0);
    chk("rstmid.req_ready", 64'(req_ready_o), 64'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    begin
      int unsigned seen = 0;
      repeat (40) begin @(negedge clk_i); if (rsp_valid_o) seen++; end
      chk("rstmid.no_rsp", 64'(seen), 64'h0);
    end
    chk("rstmid.req_ready_after", 64'(req_ready_o), 64'h1);
    run_txn(tbl[0]);

    chk("protocol_stability", 64'(proto_err), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
